// File: rtl/top_if_pkg.sv
// top_if_pkg: shared FSM encoding, instruction constants and helpers for the fetch stage
package top_if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;

    function automatic int clogb2(input int depth);
        int r;
        r = 0;
        for (int v = depth - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/top_if_memoria_programa.sv
// memoria_programa: program memory with asynchronous read and synchronous write
module memoria_programa
    import top_if_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAM_DEPTH = 2048,
    parameter int ADDR_W    = clogb2(RAM_DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_wr_mem,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem [RAM_DEPTH];

    // write port: one word per edge when strobed
    always_ff @(posedge i_clock) begin
        if (i_wr_mem) mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/top_if.sv
// top_if: MIPS fetch stage with PC, program memory, IF/ID latch, run FSM and cycle counter
module top_if
    import top_if_pkg::*;
#(
    parameter int LENGTH_INSTRUCTION = 32,
    parameter int CANT_BITS_ADDR     = 11,
    parameter int RAM_DEPTH          = 2048,
    parameter int CANT_BITS_CICLOS   = 32
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    input  logic                          i_branch_control,
    input  logic                          i_stall,
    input  logic                          i_enable_pipeline,
    input  logic                          i_enable_etapa,
    input  logic                          i_wr_mem,
    input  logic [CANT_BITS_ADDR-1:0]     i_wr_addr,
    input  logic [LENGTH_INSTRUCTION-1:0] i_wr_data,
    output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
    output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_pc,
    output logic                          o_halt,
    output logic [CANT_BITS_CICLOS-1:0]   o_cycle_count
);

    state_t                          state, state_n;
    logic [CANT_BITS_ADDR-1:0]       pc, pc_n, apc_n, pc_inc;
    logic [LENGTH_INSTRUCTION-1:0]   ir_n, mem_word;
    logic                            halt_n;
    logic [CANT_BITS_CICLOS-1:0]     cnt_n, cnt_inc;

    memoria_programa #(
        .WIDTH     (LENGTH_INSTRUCTION),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_mem (
        .i_clock   (i_clock),
        .i_wr_mem  (i_wr_mem && state == IDLE),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (pc),
        .o_rd_data (mem_word)
    );

    assign pc_inc  = pc + CANT_BITS_ADDR'(1);
    assign cnt_inc = o_cycle_count + CANT_BITS_CICLOS'(1);
    assign o_pc    = pc;

    // next state and next register values; the start edge counts as the first executed cycle
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = o_instruction;
        apc_n   = o_out_adder_pc;
        halt_n  = o_halt;
        cnt_n   = o_cycle_count;
        case (state)
            IDLE: begin
                if (i_enable_etapa) begin
                    state_n = RUN;
                    cnt_n   = i_enable_pipeline ? cnt_inc : o_cycle_count;
                end
            end
            RUN: begin
                if (i_enable_pipeline) begin
                    cnt_n = cnt_inc;
                    if (!i_stall) begin
                        ir_n  = mem_word;
                        apc_n = pc_inc;
                        if (mem_word == HALT_INSTRUCTION) begin
                            halt_n  = 1'b1;
                            state_n = HALTED;
                        end else begin
                            pc_n = i_branch_control ? i_branch_dir : pc_inc;
                        end
                    end
                end
            end
            HALTED: ;
            default: state_n = IDLE;
        endcase
    end

    // state, PC, IF/ID latch and counter registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_soft_reset) begin
            state          <= IDLE;
            pc             <= '0;
            o_instruction  <= NOP_INSTRUCTION;
            o_out_adder_pc <= '0;
            o_halt         <= 1'b0;
            o_cycle_count  <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            o_instruction  <= ir_n;
            o_out_adder_pc <= apc_n;
            o_halt         <= halt_n;
            o_cycle_count  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_top_if.sv
// tb_top_if: randomized and directed checks of top_if against a behavioural fetch-stage model
module tb_top_if;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] branch_dir = '0;
    logic        branch_control = 1'b0;
    logic        stall = 1'b0;
    logic        enable_pipeline = 1'b0;
    logic        enable_etapa = 1'b0;
    logic        wr_mem = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] instruction;
    logic [10:0] out_adder_pc;
    logic [10:0] pc;
    logic        halt;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] m_mem [2048];
    logic [10:0] m_pc, m_apc;
    logic [31:0] m_ir, m_cnt;
    logic        m_halt;
    int          m_mode;

    always #5 clk = ~clk;

    top_if dut (
        .i_clock           (clk),
        .i_soft_reset      (rst_n),
        .i_branch_dir      (branch_dir),
        .i_branch_control  (branch_control),
        .i_stall           (stall),
        .i_enable_pipeline (enable_pipeline),
        .i_enable_etapa    (enable_etapa),
        .i_wr_mem          (wr_mem),
        .i_wr_addr         (wr_addr),
        .i_wr_data         (wr_data),
        .o_instruction     (instruction),
        .o_out_adder_pc    (out_adder_pc),
        .o_pc              (pc),
        .o_halt            (halt),
        .o_cycle_count     (cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // mode 0 = loading, 1 = running, 2 = stopped on halt word
    task automatic model_step();
        logic [31:0] w;
        logic [10:0] nxt;
        if (!rst_n) begin
            m_pc = 0; m_ir = 0; m_apc = 0; m_halt = 0; m_cnt = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (wr_mem) m_mem[wr_addr] = wr_data;
            if (enable_etapa) begin
                m_mode = 1;
                if (enable_pipeline) m_cnt = m_cnt + 1;
            end
        end else if (m_mode == 1 && enable_pipeline) begin
            m_cnt = m_cnt + 1;
            if (!stall) begin
                w = m_mem[m_pc];
                nxt = m_pc + 11'd1;
                m_ir = w;
                m_apc = nxt;
                if (w == HALT) begin
                    m_halt = 1;
                    m_mode = 2;
                end else begin
                    m_pc = branch_control ? branch_dir : nxt;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("pc", {21'd0, pc}, {21'd0, m_pc});
        check("instr", instruction, m_ir);
        check("adder_pc", {21'd0, out_adder_pc}, {21'd0, m_apc});
        check("halt", {31'd0, halt}, {31'd0, m_halt});
        check("count", cycle_count, m_cnt);
    endtask

    task automatic do_reset();
        rst_n = 0; enable_etapa = 0; wr_mem = 0; branch_control = 0; stall = 0;
        tick();
        rst_n = 1;
        check("rst_pc", {21'd0, pc}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_count", cycle_count, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        enable_pipeline = 1;
        do_reset();
        for (int a = 0; a < 2048; a++) begin
            d = $urandom;
            if (d == HALT) d = 32'h0;
            if (a == 0) d = 32'h2001_0005;
            if (a == 1) d = 32'h2002_0003;
            if (a == 2) d = HALT;
            wr_mem = 1; wr_addr = 11'(a); wr_data = d;
            tick();
        end
        wr_mem = 0; enable_etapa = 1;
        tick();
        enable_etapa = 0;
        for (int i = 0; i < 10 && !halt; i++) tick();
        check("t1_halt", {31'd0, halt}, 32'd1);
        check("t1_pc", {21'd0, pc}, 32'd2);
        check("t1_count", cycle_count, 32'd4);
        check("t1_instr", instruction, HALT);
        check("t1_adder_pc", {21'd0, out_adder_pc}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            wr_mem = 1; wr_addr = 11'd2; wr_data = 32'h1234_5678;
            branch_control = 1; branch_dir = 11'h55;
            tick();
        end
        do_reset();
        wr_mem = 1; wr_addr = 11'd2; wr_data = 32'h2003_000A;
        tick();
        wr_mem = 0; enable_etapa = 1;
        tick();
        for (int i = 0; i < 800; i++) begin
            enable_etapa = 1'($urandom_range(0, 1));
            enable_pipeline = $urandom_range(0, 9) != 0;
            stall = $urandom_range(0, 4) == 0;
            branch_control = $urandom_range(0, 5) == 0;
            branch_dir = 11'($urandom);
            wr_mem = 1'($urandom_range(0, 1));
            wr_addr = 11'd3;
            wr_data = $urandom;
            tick();
        end
        wr_mem = 0; enable_pipeline = 1; stall = 0;
        branch_control = 1; branch_dir = 11'h7FF;
        tick();
        branch_control = 0;
        tick();
        check("wrap_adder_pc", {21'd0, out_adder_pc}, 32'd0);
        check("wrap_pc", {21'd0, pc}, 32'd0);
        tick();
        stall = 1; branch_control = 1; branch_dir = 11'h100;
        for (int i = 0; i < 3; i++) tick();
        stall = 0; branch_control = 0;
        tick();
        enable_pipeline = 0;
        for (int i = 0; i < 5; i++) tick();
        enable_pipeline = 1;
        do_reset();
        enable_etapa = 1;
        for (int i = 0; i < 7; i++) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
